// File: rtl/sdrc_pkg.sv
// Shared types and defaults for the SDRAM controller core.
// Used by sdrc_burst_splitter and sdrc_addr_add.
package sdrc_pkg;

  localparam int SDRC_APP_AW   = 26;
  localparam int SDRC_COL_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } bsplit_state_t;

  typedef logic [3:0] bst_len_t;

endpackage

// File: rtl/sdrc_addr_add.sv
// Address-increment adder: addr + zero-extended burst length.
// The carry-out is dropped, so the address wraps at 2^AW.
module sdrc_addr_add
  import sdrc_pkg::*;
#(
  parameter int AW = SDRC_APP_AW
) (
  input  logic [AW-1:0] addr,
  input  bst_len_t      inc,
  output logic [AW-1:0] sum
);

  assign sum = addr + {{(AW-4){1'b0}}, inc};

endmodule

// File: rtl/sdrc_burst_splitter.sv
// Splits a (start address, word count) request into bursts of at most MAX_BURST words.
// Define SDRC_PAGE_SPLIT_EN to also stop every burst at a 2^COL_BITS page boundary.
module sdrc_burst_splitter
  import sdrc_pkg::*;
#(
  parameter int APP_AW    = SDRC_APP_AW,
  parameter int LEN_W     = 9,
  parameter int MAX_BURST = 8,
  parameter int COL_BITS  = SDRC_COL_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [APP_AW-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              req_wr,
  output logic              bst_valid,
  input  logic              bst_ready,
  output logic [APP_AW-1:0] bst_addr,
  output bst_len_t          bst_len,
  output logic              bst_wr,
  output logic              bst_last,
  output logic              busy,
  output logic              done
);

  localparam logic [COL_BITS:0] PAGE_WORDS = {1'b1, {COL_BITS{1'b0}}};
  localparam logic [LEN_W-1:0]  MAX_LEN    = LEN_W'(MAX_BURST);

  bsplit_state_t     state;
  logic [APP_AW-1:0] cur_addr;
  logic [APP_AW-1:0] next_addr;
  logic [LEN_W-1:0]  rem;
  logic [LEN_W-1:0]  next_rem;
  logic [COL_BITS:0] room_req;
  logic [COL_BITS:0] room_next;
  bst_len_t          first_chunk;
  bst_len_t          next_chunk;

  function automatic bst_len_t chunk_of(input logic [LEN_W-1:0] r, input logic [COL_BITS:0] room);
    logic [LEN_W-1:0] lim;
    lim = (r < MAX_LEN) ? r : MAX_LEN;
    if (32'(room) < 32'(lim))
      lim = LEN_W'(room);
    return bst_len_t'(lim);
  endfunction

  sdrc_addr_add #(.AW(APP_AW)) u_addr_add (
    .addr (cur_addr),
    .inc  (bst_len),
    .sum  (next_addr)
  );

  // Without page splitting the room term is a full page, which never limits a burst.
`ifdef SDRC_PAGE_SPLIT_EN
  assign room_req  = PAGE_WORDS - {1'b0, req_addr[COL_BITS-1:0]};
  assign room_next = PAGE_WORDS - {1'b0, next_addr[COL_BITS-1:0]};
`else
  assign room_req  = PAGE_WORDS;
  assign room_next = PAGE_WORDS;
`endif

  assign next_rem    = rem - {{(LEN_W-4){1'b0}}, bst_len};
  assign first_chunk = chunk_of(req_len, room_req);
  assign next_chunk  = chunk_of(next_rem, room_next);

  assign req_ready = (state == IDLE);
  assign bst_valid = (state == ISSUE);
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cur_addr <= '0;
      rem      <= '0;
      bst_addr <= '0;
      bst_len  <= '0;
      bst_wr   <= 1'b0;
      bst_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_len == '0) begin
              state <= DONE;
            end else begin
              state    <= ISSUE;
              cur_addr <= req_addr;
              rem      <= req_len;
              bst_addr <= req_addr;
              bst_len  <= first_chunk;
              bst_wr   <= req_wr;
              bst_last <= ({{(LEN_W-4){1'b0}}, first_chunk} == req_len);
            end
          end
        end
        ISSUE: begin
          if (bst_ready) begin
            if (bst_last) begin
              state <= DONE;
            end else begin
              // The following burst is registered in the same cycle, keeping bursts back-to-back.
              cur_addr <= next_addr;
              rem      <= next_rem;
              bst_addr <= next_addr;
              bst_len  <= next_chunk;
              bst_last <= ({{(LEN_W-4){1'b0}}, next_chunk} == next_rem);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
